alsu_gen: RTL
=============

Name: alsu_gen

Overview:
- Parametrised, handshaked successor to the 3-bit ALSU.
- Operands are WIDTH-bit signed values; the result register is 2*WIDTH bits.
- MULT is a multi-cycle sequential shift-add controlled by an FSM.
- An invalid operation drives a rate-divided LED blink that persists until the next valid operation.
- Sits between the operand/opcode front end and the display/result consumer.

Parameters:
- WIDTH, 8: operand width in bits; result width is 2*WIDTH.
- INPUT_PRIORITY, "A": "A" or "B"; selects which operand wins when both bypass flags or both reduction flags are set.
- FULL_ADDER, "ON": "ON" means ADD includes cin; "OFF" means cin is ignored.
- LED_WIDTH, 16: width of the leds output.
- BLINK_CYCLES, 4: number of clk cycles between LED toggles while the invalid flag is set; must be at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- opcode  in  3  opcode_e.
- A  in  WIDTH  signed operand A.
- B  in  WIDTH  signed operand B.
- cin  in  1  carry-in, unsigned.
- red_op_A  in  1  reduce A for OR/XOR.
- red_op_B  in  1  reduce B for OR/XOR.
- bypass_A  in  1  pass A to the output.
- bypass_B  in  1  pass B to the output.
- direction  in  1  1 = left, 0 = right (SHIFT/ROTATE).
- serial_in  in  1  shift-in bit.
- out_valid  out  1  one-cycle pulse: out updated this cycle.
- out  out  2*WIDTH  signed result register.
- leds  out  LED_WIDTH  invalid indicator.

Behaviour:
- Reset (rst=0, asynchronous):
  - out=0, out_valid=0, leds=0, in_ready=1.
  - FSM returns to IDLE, blink counter=0, invalid flag=0.
  - Any in-flight MULT is aborted.
- Accept: an operation is taken on the edge where in_valid && in_ready; all inputs are captured at that edge (edge k).
- Single-cycle ops:
  - out and out_valid=1 are updated at edge k+1.
  - in_ready stays 1, so back-to-back accepts on consecutive edges are legal.
- Result priority, highest first:
  1. Both bypass flags set: the INPUT_PRIORITY operand, sign-extended.
  2. bypass_A alone: A, sign-extended.
  3. bypass_B alone: B, sign-extended.
  4. Invalid: out=0.
  5. Otherwise the opcode result.
- Invalid condition: opcode is 6 or 7, or (red_op_A|red_op_B) with opcode > XOR.
- Bypass results are never invalid.
- OR/XOR results:
  - Both red flags set: reduction of the INPUT_PRIORITY operand.
  - One red flag set: reduction of that operand.
  - Neither set: bitwise OR/XOR, sign-extended.
  - Reduction results are zero-extended 1-bit values.
- ADD: sext(A)+sext(B), plus cin when FULL_ADDER=="ON"; no overflow is possible in 2*WIDTH bits.
- SHIFT: shifts the current out by 1 position.
  - Left: {out[2W-2:0], serial_in}.
  - Right: {serial_in, out[2W-1:1]}.
- ROTATE: rotates the current out by 1 position.
  - Left: {out[2W-2:0], out[2W-1]}.
  - Right: {out[0], out[2W-1:1]}.
- MULT FSM states IDLE -> MUL -> DONE -> IDLE:
  - At accept: in_ready=0.
  - Edges k+1..k+WIDTH perform the WIDTH shift-add iterations on magnitudes.
  - At edge k+WIDTH+1: out = the signed product (sign corrected), out_valid=1, in_ready=1 again, FSM returns to IDLE.
  - in_valid is ignored while in_ready=0.
  - out holds its previous value during MUL.
  - MULT with a bypass flag set is a single-cycle bypass and does not enter MUL.
- out_valid is 0 whenever no result is written; out holds its value.
- LEDs:
  - At the result edge of an invalid op: invalid flag=1, leds set to all ones, counter=0.
  - While the flag is set: the counter increments every cycle; on reaching BLINK_CYCLES-1, leds invert and the counter wraps to 0.
  - A further invalid op re-arms leds to all ones.
  - Any non-invalid result clears the flag, leds and counter at its result edge.

Decomposition:
- Package alsu_gen_pkg:
  - opcode_e: OR=0, XOR, ADD, MULT, SHIFT, ROTATE, INVALID6, INVALID7.
  - state_e: IDLE, MUL, DONE.
  - Function is_invalid(opcode, red_op_A, red_op_B).
- Sub-module alsu_seq_mult (WIDTH):
  - Ports: start, a, b, busy, done, product.
  - Owns the iteration counter and sign correction.

Test Plan:
1. Start MULT A=3, B=4; assert rst=0 at edge k+3 -> out=0, out_valid=0, leds=0, in_ready=1 immediately, without waiting for a clock edge.
2. ADD, WIDTH=8, A=8'hFD, B=8'h05, cin=1, FULL_ADDER="ON" -> out=16'h0003 at k+1, out_valid high 1 cycle; repeat with "OFF" -> 16'h0002.
3. MULT A=8'hF9 (-7), B=8'h09 -> in_ready=0 from k to k+9; out=16'hFFC1 (-63) with out_valid at k+9; an in_valid pulse at k+4 is ignored.
4. Opcode 7, no bypass:
   - out=0, leds=16'hFFFF at k+1.
   - leds=16'h0000 4 cycles later (BLINK_CYCLES=4), then 16'hFFFF after 4 more.
   - Then accept OR A=1, B=2 -> out=16'h0003 and leds=0.
5. After out=16'h0003:
   - SHIFT direction=1, serial_in=1 -> 16'h0007.
   - ROTATE direction=0 -> 16'h8003.
   - ROTATE direction=1 -> 16'h0007.
6. INPUT_PRIORITY="A", bypass_A=bypass_B=1, A=8'h80, B=8'h01, opcode=7 -> out=16'hFF80, leds remain 0.

Source files
------------

// File: rtl/alsu_gen_pkg.sv
// Shared opcode and FSM state types for the generic ALSU, plus the
// invalid-operation rule used by both the request decode and the result path.
package alsu_gen_pkg;

  typedef enum logic [2:0] {
    OR       = 3'd0,
    XOR      = 3'd1,
    ADD      = 3'd2,
    MULT     = 3'd3,
    SHIFT    = 3'd4,
    ROTATE   = 3'd5,
    INVALID6 = 3'd6,
    INVALID7 = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reduction flags only make sense for OR/XOR; anything above XOR with them set is rejected.
  function automatic logic is_invalid(opcode_e op, logic red_a, logic red_b);
    return (op == INVALID6) || (op == INVALID7) || ((red_a | red_b) && (op > XOR));
  endfunction

endpackage

// File: rtl/alsu_gen_if.sv
// Request/response bundle between the operand front end and the ALSU;
// the front end is the master, the ALSU the slave.
interface alsu_gen_if #(
  parameter int WIDTH     = 8,
  parameter int LED_WIDTH = 16
);
  import alsu_gen_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  opcode_e                   opcode;
  logic signed [WIDTH-1:0]   A;
  logic signed [WIDTH-1:0]   B;
  logic                      cin;
  logic                      red_op_A;
  logic                      red_op_B;
  logic                      bypass_A;
  logic                      bypass_B;
  logic                      direction;
  logic                      serial_in;
  logic                      out_valid;
  logic signed [2*WIDTH-1:0] out;
  logic [LED_WIDTH-1:0]      leds;

  modport master (
    output in_valid, opcode, A, B, cin, red_op_A, red_op_B,
           bypass_A, bypass_B, direction, serial_in,
    input  in_ready, out_valid, out, leds
  );

  modport slave (
    input  in_valid, opcode, A, B, cin, red_op_A, red_op_B,
           bypass_A, bypass_B, direction, serial_in,
    output in_ready, out_valid, out, leds
  );

endinterface

// File: rtl/alsu_seq_mult.sv
// Sequential signed multiplier: captures magnitudes on start, performs one
// shift-add step per cycle for WIDTH cycles, and applies the sign at the output.
module alsu_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic signed [WIDTH-1:0]   a_i,
  input  logic signed [WIDTH-1:0]   b_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic signed [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic               busy_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // The most negative operand still fits as an unsigned WIDTH-bit magnitude.
  assign mag_a = a_i[WIDTH-1] ? -a_i : a_i;
  assign mag_b = b_i[WIDTH-1] ? -b_i : b_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, mag_a};
      acc_q    <= '0;
      mplier_q <= mag_b;
      cnt_q    <= '0;
      neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/alsu_gen.sv
// Handshaked parametrised ALSU: single-cycle logic/arith/shift ops, a
// multi-cycle MULT under an IDLE/MUL/DONE FSM, and a blinking invalid indicator.
module alsu_gen #(
  parameter int    WIDTH          = 8,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_WIDTH      = 16,
  parameter int    BLINK_CYCLES   = 4
) (
  input logic       clk,
  input logic       rst,
  alsu_gen_if.slave bus
);
  import alsu_gen_pkg::*;

  localparam int RW      = 2 * WIDTH;
  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");
  localparam int BCW     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  state_e               state_q, state_d;
  logic                 pend_q;
  opcode_e              opc_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 cin_q, red_a_q, red_b_q, byp_a_q, byp_b_q, dir_q, sin_q;
  logic [RW-1:0]        out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic                 flag_q, flag_d;
  logic [BCW-1:0]       cnt_q, cnt_d;
  logic                 accept, mult_start, mul_busy, mul_done;
  logic signed [RW-1:0] mul_product;
  logic [RW-1:0]        sext_a, sext_b, res_c;
  logic [WIDTH-1:0]     red_src;
  logic                 invalid_c, wr_invalid;

  assign bus.in_ready = (state_q == IDLE) && !mul_busy;
  assign accept       = bus.in_valid && bus.in_ready;
  assign mult_start   = accept && (bus.opcode == MULT) && !(bus.bypass_A || bus.bypass_B)
                        && !is_invalid(bus.opcode, bus.red_op_A, bus.red_op_B);

  alsu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mult_start),
    .a_i       (bus.A),
    .b_i       (bus.B),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mult_start) state_d = MUL;
      MUL:     if (mul_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every accepted request is captured; pend_q marks a single-cycle result due next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= 1'b0;
      opc_q   <= OR;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      red_a_q <= 1'b0;
      red_b_q <= 1'b0;
      byp_a_q <= 1'b0;
      byp_b_q <= 1'b0;
      dir_q   <= 1'b0;
      sin_q   <= 1'b0;
    end else begin
      pend_q <= accept && !mult_start;
      if (accept) begin
        opc_q   <= bus.opcode;
        a_q     <= bus.A;
        b_q     <= bus.B;
        cin_q   <= bus.cin;
        red_a_q <= bus.red_op_A;
        red_b_q <= bus.red_op_B;
        byp_a_q <= bus.bypass_A;
        byp_b_q <= bus.bypass_B;
        dir_q   <= bus.direction;
        sin_q   <= bus.serial_in;
      end
    end
  end

  assign sext_a    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign sext_b    = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign red_src   = (red_a_q && (!red_b_q || PRIO_A)) ? a_q : b_q;
  assign invalid_c = !(byp_a_q || byp_b_q) && is_invalid(opc_q, red_a_q, red_b_q);

  always_comb begin
    res_c = '0;
    if (byp_a_q && byp_b_q) res_c = PRIO_A ? sext_a : sext_b;
    else if (byp_a_q)       res_c = sext_a;
    else if (byp_b_q)       res_c = sext_b;
    else if (!invalid_c) begin
      case (opc_q)
        OR:      res_c = (red_a_q || red_b_q) ? {{(RW-1){1'b0}}, |red_src} : (sext_a | sext_b);
        XOR:     res_c = (red_a_q || red_b_q) ? {{(RW-1){1'b0}}, ^red_src} : (sext_a ^ sext_b);
        ADD:     res_c = sext_a + sext_b + {{(RW-1){1'b0}}, cin_q & USE_CIN};
        SHIFT:   res_c = dir_q ? {out_q[RW-2:0], sin_q} : {sin_q, out_q[RW-1:1]};
        ROTATE:  res_c = dir_q ? {out_q[RW-2:0], out_q[RW-1]} : {out_q[0], out_q[RW-1:1]};
        default: res_c = '0;
      endcase
    end
  end

  // A result edge re-arms or clears the indicator; otherwise the flag drives the blink.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    wr_invalid  = 1'b0;
    leds_d      = leds_q;
    flag_d      = flag_q;
    cnt_d       = cnt_q;
    if (state_q == DONE) begin
      out_d       = mul_product;
      out_valid_d = 1'b1;
    end else if (pend_q) begin
      out_d       = res_c;
      out_valid_d = 1'b1;
      wr_invalid  = invalid_c;
    end
    if (out_valid_d) begin
      flag_d = wr_invalid;
      leds_d = wr_invalid ? '1 : '0;
      cnt_d  = '0;
    end else if (flag_q) begin
      if (cnt_q == BCW'(BLINK_CYCLES - 1)) begin
        leds_d = ~leds_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      leds_q      <= '0;
      flag_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      leds_q      <= leds_d;
      flag_q      <= flag_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.leds      = leds_q;

endmodule
